// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared definitions for the SD card-side CMD line responder: FSM states,
// response type codes, frame lengths and the CRC7 step/response framing helpers.
package sd_card_cmd_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT_RESP,
        ST_TX
    } state_e;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'd0,
        RESP_R48       = 2'd1,
        RESP_R136      = 2'd2,
        RESP_R48_NOCRC = 2'd3
    } resp_type_e;

    localparam logic [6:0]  CRC7_POLY      = 7'h09;
    localparam logic [7:0]  CMD_FRAME_LEN  = 8'd48;
    localparam logic [7:0]  R48_FRAME_LEN  = 8'd48;
    localparam logic [7:0]  R136_FRAME_LEN = 8'd136;

    function automatic logic [6:0] crc7_step(input logic [6:0] rem, input logic din);
        logic fb;
        fb = rem[6] ^ din;
        return {rem[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

    // Left-aligned response bits ahead of the CRC field; R48 leaves the low 88 bits unused.
    function automatic logic [127:0] resp_frame_bits(input resp_type_e t, input logic [127:0] p);
        logic [5:0] idx;
        idx = (t == RESP_R48_NOCRC) ? 6'h3F : p[37:32];
        if (t == RESP_R136)
            return {2'b00, 6'h3F, p[127:8]};
        return {2'b00, idx, p[31:0], 88'd0};
    endfunction

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// CMD line pins plus the command/response handshake between the responder and card logic.
interface sd_card_cmd_responder_if;
    logic         cmd_pin_in;
    logic         cmd_pin_out;
    logic         cmd_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         crc_err;
    logic         frame_err;
    logic         resp_timeout;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_type;
    logic [127:0] resp_payload;
    logic         busy;

    modport slave (
        input  cmd_pin_in, resp_valid, resp_type, resp_payload,
        output cmd_pin_out, cmd_oe, cmd_valid, cmd_index, cmd_arg,
               crc_err, frame_err, resp_timeout, resp_ready, busy
    );

    modport master (
        output cmd_pin_in, resp_valid, resp_type, resp_payload,
        input  cmd_pin_out, cmd_oe, cmd_valid, cmd_index, cmd_arg,
               crc_err, frame_err, resp_timeout, resp_ready, busy
    );
endinterface

// File: rtl/sd_card_cmd_responder_crc7.sv
// Serial CRC7 (x^7+x^3+1); clear and enable in the same cycle restarts with the new bit.
module sd_card_cmd_responder_crc7
    import sd_card_cmd_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] rem_q;
    logic [6:0] rem_d;
    logic [6:0] base;

    always_comb begin
        base  = clr ? 7'h00 : rem_q;
        rem_d = en ? crc7_step(base, din) : base;
    end

    always_ff @(posedge clk) begin
        if (rst) rem_q <= '0;
        else     rem_q <= rem_d;
    end

    assign crc = rem_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit host commands, checks framing/CRC7,
// then serialises R48/R3/R136 responses after the NCR gap.
module sd_card_cmd_responder
    import sd_card_cmd_responder_pkg::*;
#(
    parameter int unsigned NCR_CYCLES    = 2,
    parameter int unsigned RESP_WAIT_MAX = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    sd_card_cmd_responder_if.slave  bus
);

    localparam int unsigned WAIT_W = $clog2(RESP_WAIT_MAX + 1);

    state_e        state_q, state_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic [46:0]   rx_sr_q, rx_sr_d;
    logic [7:0]    ncr_q, ncr_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic          taken_q, taken_d;
    logic [127:0]  tx_sr_q, tx_sr_d;
    logic          tx_long_q, tx_long_d;
    logic          tx_nocrc_q, tx_nocrc_d;
    logic [7:0]    tx_cnt_q, tx_cnt_d;
    logic          cmd_pin_out_q, cmd_pin_out_d;
    logic          cmd_oe_q, cmd_oe_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [5:0]    cmd_index_q, cmd_index_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          crc_err_q, crc_err_d;
    logic          frame_err_q, frame_err_d;
    logic          resp_timeout_q, resp_timeout_d;
    logic          resp_ready_q, resp_ready_d;
    logic          busy_q, busy_d;

    resp_type_e    rt_in;
    logic          handshake;
    logic          long_now;
    logic          nocrc_now;
    logic [127:0]  frame_now;
    logic [7:0]    tx_last;
    logic [7:0]    tx_data_len;
    logic [7:0]    tx_nxt;
    logic [2:0]    tx_crc_sel;

    logic          rx_crc_clr, rx_crc_en;
    logic          tx_crc_clr, tx_crc_en, tx_crc_din;
    logic [6:0]    rx_crc, tx_crc;

    sd_card_cmd_responder_crc7 u_rx_crc (
        .clk (clock),
        .rst (reset),
        .clr (rx_crc_clr),
        .en  (rx_crc_en),
        .din (bus.cmd_pin_in),
        .crc (rx_crc)
    );

    sd_card_cmd_responder_crc7 u_tx_crc (
        .clk (clock),
        .rst (reset),
        .clr (tx_crc_clr),
        .en  (tx_crc_en),
        .din (tx_crc_din),
        .crc (tx_crc)
    );

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_sr_d        = rx_sr_q;
        ncr_d          = (ncr_q == 8'hFF) ? ncr_q : ncr_q + 8'd1;
        wait_inc       = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        wait_d         = wait_q;
        taken_d        = taken_q;
        tx_sr_d        = tx_sr_q;
        tx_long_d      = tx_long_q;
        tx_nocrc_d     = tx_nocrc_q;
        tx_cnt_d       = tx_cnt_q;
        cmd_pin_out_d  = cmd_pin_out_q;
        cmd_oe_d       = cmd_oe_q;
        cmd_valid_d    = 1'b0;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;
        crc_err_d      = 1'b0;
        frame_err_d    = 1'b0;
        resp_timeout_d = 1'b0;
        resp_ready_d   = resp_ready_q;
        rx_crc_clr     = 1'b0;
        rx_crc_en      = 1'b0;
        tx_crc_clr     = 1'b0;
        tx_crc_en      = 1'b0;
        tx_crc_din     = 1'b0;

        rt_in       = resp_type_e'(bus.resp_type);
        handshake   = resp_ready_q && bus.resp_valid;
        long_now    = taken_q ? tx_long_q  : (rt_in == RESP_R136);
        nocrc_now   = taken_q ? tx_nocrc_q : (rt_in == RESP_R48_NOCRC);
        frame_now   = handshake ? resp_frame_bits(rt_in, bus.resp_payload) : tx_sr_q;
        tx_last     = tx_long_q ? (R136_FRAME_LEN - 8'd1) : (R48_FRAME_LEN - 8'd1);
        tx_data_len = tx_last - 8'd7;
        tx_nxt      = tx_cnt_q + 8'd1;
        tx_crc_sel  = 3'(8'd6 + tx_data_len - tx_nxt);

        case (state_q)
            ST_IDLE: begin
                if (!bus.cmd_pin_in) begin
                    state_d    = ST_RX;
                    bit_cnt_d  = 8'd1;
                    rx_crc_clr = 1'b1;
                    rx_crc_en  = 1'b1;
                end
            end
            ST_RX: begin
                rx_sr_d   = {rx_sr_q[45:0], bus.cmd_pin_in};
                rx_crc_en = (bit_cnt_q < CMD_FRAME_LEN - 8'd8);
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q == CMD_FRAME_LEN - 8'd1) begin
                    state_d = ST_CHECK;
                    ncr_d   = '0;
                end
            end
            ST_CHECK: begin
                if (!rx_sr_q[46] || !rx_sr_q[0]) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (rx_sr_q[7:1] != rx_crc) begin
                    crc_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cmd_valid_d  = 1'b1;
                    cmd_index_d  = rx_sr_q[45:40];
                    cmd_arg_d    = rx_sr_q[39:8];
                    state_d      = ST_WAIT_RESP;
                    resp_ready_d = 1'b1;
                    wait_d       = '0;
                    taken_d      = 1'b0;
                end
            end
            ST_WAIT_RESP: begin
                if (handshake && rt_in == RESP_NONE) begin
                    resp_ready_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (handshake || taken_q) begin
                    // Response may be accepted before the NCR gap expires; hold it until then.
                    resp_ready_d = 1'b0;
                    taken_d      = 1'b1;
                    if (handshake) begin
                        tx_sr_d    = frame_now;
                        tx_long_d  = long_now;
                        tx_nocrc_d = nocrc_now;
                    end
                    if (ncr_d >= 8'(NCR_CYCLES)) begin
                        state_d       = ST_TX;
                        taken_d       = 1'b0;
                        cmd_oe_d      = 1'b1;
                        cmd_pin_out_d = frame_now[127];
                        tx_sr_d       = frame_now << 1;
                        tx_cnt_d      = '0;
                        tx_crc_clr    = 1'b1;
                        tx_crc_en     = !long_now;
                        tx_crc_din    = frame_now[127];
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(RESP_WAIT_MAX)) begin
                        resp_timeout_d = 1'b1;
                        resp_ready_d   = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_TX: begin
                if (tx_cnt_q == tx_last) begin
                    state_d       = ST_IDLE;
                    cmd_oe_d      = 1'b0;
                    cmd_pin_out_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_nxt;
                    if (tx_nxt < tx_data_len) begin
                        cmd_pin_out_d = tx_sr_q[127];
                        tx_sr_d       = tx_sr_q << 1;
                        tx_crc_en     = !tx_long_q || (tx_nxt >= 8'd8);
                        tx_crc_din    = tx_sr_q[127];
                    end else if (tx_nxt < tx_last) begin
                        cmd_pin_out_d = tx_nocrc_q ? 1'b1 : tx_crc[tx_crc_sel];
                    end else begin
                        cmd_pin_out_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            rx_sr_q        <= '0;
            ncr_q          <= '0;
            wait_q         <= '0;
            taken_q        <= 1'b0;
            tx_sr_q        <= '0;
            tx_long_q      <= 1'b0;
            tx_nocrc_q     <= 1'b0;
            tx_cnt_q       <= '0;
            cmd_pin_out_q  <= 1'b1;
            cmd_oe_q       <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_index_q    <= '0;
            cmd_arg_q      <= '0;
            crc_err_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_sr_q        <= rx_sr_d;
            ncr_q          <= ncr_d;
            wait_q         <= wait_d;
            taken_q        <= taken_d;
            tx_sr_q        <= tx_sr_d;
            tx_long_q      <= tx_long_d;
            tx_nocrc_q     <= tx_nocrc_d;
            tx_cnt_q       <= tx_cnt_d;
            cmd_pin_out_q  <= cmd_pin_out_d;
            cmd_oe_q       <= cmd_oe_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
            crc_err_q      <= crc_err_d;
            frame_err_q    <= frame_err_d;
            resp_timeout_q <= resp_timeout_d;
            resp_ready_q   <= resp_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.cmd_pin_out  = cmd_pin_out_q;
    assign bus.cmd_oe       = cmd_oe_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_index    = cmd_index_q;
    assign bus.cmd_arg      = cmd_arg_q;
    assign bus.crc_err      = crc_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.resp_ready   = resp_ready_q;
    assign bus.busy         = busy_q;

endmodule
